output_pack_writer: RTL and testbench

OUTPUT_PACK_WRITER -- requirements
Module: output_pack_writer

---
 rtl/output_pack_writer_pkg.sv | 15 +
 rtl/output_word_fifo.sv | 50 +++++
 rtl/output_pack_writer.sv | 124 ++++++++++++
 tb/tb_output_pack_writer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_pack_writer_pkg.sv
// Shared output-pipeline definitions: writer FSM states and word geometry.
package output_pack_writer_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/output_word_fifo.sv
// Word FIFO between the byte packer and the output memory write port.
module output_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             one_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Extra MSB on each pointer distinguishes full from empty when indices match.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign one_o   = ((wr_ptr_q - rd_ptr_q) == PTR_ONE);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO still lands if a slot is freed in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/output_pack_writer.sv
// Packs a byte stream little-endian into 32-bit words and writes them to output memory.
module output_pack_writer
    import output_pack_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start_i,
    input  logic [15:0] wr_base_i,
    input  logic [7:0]  byte_in_i,
    input  logic        byte_valid_i,
    input  logic        stream_done_i,
    output logic        wr_req_o,
    output logic [15:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    input  logic        wr_ack_i,
    output logic        overflow_o,
    output logic        done_o
);

    state_e            state_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic [WORD_W-1:0] pack_q;
    logic [WORD_W-1:0] pack_d;
    logic [15:0]       addr_q;
    logic              ovf_q;
    logic              done_q;

    logic              push;
    logic              pop;
    logic [WORD_W-1:0] push_data;
    logic [WORD_W-1:0] head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_one;

    assign pop = !fifo_empty && wr_ack_i;

    always_comb begin
        cnt_d     = cnt_q;
        pack_d    = pack_q;
        push      = 1'b0;
        push_data = pack_q;
        if (state_q == ST_RUN && byte_valid_i) begin
            if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                push      = 1'b1;
                push_data = {byte_in_i, pack_q[WORD_W-9:0]};
                cnt_d     = 2'd0;
                pack_d    = '0;
            end else begin
                pack_d[{cnt_q, 3'b000} +: 8] = byte_in_i;
                cnt_d                        = cnt_q + 2'd1;
            end
        end else if (state_q == ST_FLUSH && cnt_q != 2'd0) begin
            // Unfilled upper bytes are already zero since the packer clears on every word.
            push   = 1'b1;
            cnt_d  = 2'd0;
            pack_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pack_q  <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
            if (pop) addr_q <= addr_q + 16'd1;
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        state_q <= ST_RUN;
                        addr_q  <= wr_base_i;
                        cnt_q   <= '0;
                        pack_q  <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                ST_RUN:   if (stream_done_i) state_q <= ST_FLUSH;
                ST_FLUSH: state_q <= ST_DRAIN;
                ST_DRAIN: begin
                    // Leave as soon as the final outstanding write is acknowledged.
                    if (fifo_empty || (fifo_one && pop)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    output_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .one_o   (fifo_one)
    );

    assign wr_req_o   = !fifo_empty;
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = fifo_empty ? '0 : head;
    assign overflow_o = ovf_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_output_pack_writer.sv
// Bench for output_pack_writer: directed table, reset-mid-frame sequence, random frames.
module tb_output_pack_writer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] wr_base = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        stream_done = 1'b0;
    logic        wr_ack = 1'b0;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        overflow;
    logic        done;

    output_pack_writer #(.FIFO_DEPTH(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .frame_start_i (frame_start),
        .wr_base_i     (wr_base),
        .byte_in_i     (byte_in),
        .byte_valid_i  (byte_valid),
        .stream_done_i (stream_done),
        .wr_req_o      (wr_req),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .wr_ack_i      (wr_ack),
        .overflow_o    (overflow),
        .done_o        (done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [15:0] got_addr[$];
    logic [31:0] got_data[$];
    int          last_ack_cyc = -1;
    int          done_cnt = 0;
    int          done_cyc = -1;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(posedge clock) cyc <= cyc + 1;

    // Observe the write port away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (prev_stall) begin
                checks++;
                if (!wr_req || wr_addr !== prev_addr || wr_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got req=%0b addr=0x%0h data=0x%0h, expected req=1 addr=0x%0h data=0x%0h",
                             wr_req, wr_addr, wr_data, prev_addr, prev_data);
                end
            end
            if (wr_req && wr_ack) begin
                got_addr.push_back(wr_addr);
                got_data.push_back(wr_data);
                last_ack_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = wr_req && !wr_ack;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] base);
        got_addr.delete();
        got_data.delete();
        done_cnt     = 0;
        done_cyc     = -1;
        last_ack_cyc = -1;
        wr_base      = base;
        frame_start  = 1'b1;
        tick();
        frame_start  = 1'b0;
    endtask

    task automatic wait_done(input bit rnd_ack);
        int i;
        for (i = 0; i < 300 && done_cnt == 0; i++) begin
            if (rnd_ack) wr_ack = ($urandom % 4) != 0;
            tick();
        end
        wr_ack = 1'b1;
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: got no done pulse, expected one within 300 cycles");
        end
        repeat (3) tick();
    endtask

    typedef struct {
        logic [15:0] base;
        int          n;
        logic [7:0]  start;
        logic [7:0]  step;
        logic        stall;
        int          nw;
        logic [15:0] a0;
        logic [31:0] d0;
        logic [15:0] al;
        logic [31:0] dl;
        logic        ovf;
    } vec_t;

    vec_t        tbl[5];
    logic [7:0]  stim[$];
    logic [31:0] exp_w[$];

    initial begin
        tbl[0] = '{16'h8000, 4,  8'h11, 8'h11, 1'b0, 1, 16'h8000, 32'h44332211, 16'h8000, 32'h44332211, 1'b0};
        tbl[1] = '{16'h8000, 8,  8'h01, 8'h01, 1'b0, 2, 16'h8000, 32'h04030201, 16'h8001, 32'h08070605, 1'b0};
        tbl[2] = '{16'h2000, 5,  8'hA0, 8'h01, 1'b0, 2, 16'h2000, 32'hA3A2A1A0, 16'h2001, 32'h000000A4, 1'b0};
        tbl[3] = '{16'hFFFF, 8,  8'h30, 8'h01, 1'b0, 2, 16'hFFFF, 32'h33323130, 16'h0000, 32'h37363534, 1'b0};
        tbl[4] = '{16'h0100, 24, 8'h10, 8'h01, 1'b1, 4, 16'h0100, 32'h13121110, 16'h0103, 32'h1F1E1D1C, 1'b1};

        // Reset state
        tick();
        tick();
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        tick();

        // Directed table
        for (int c = 0; c < 5; c++) begin
            wr_ack = !tbl[c].stall;
            start_frame(tbl[c].base);
            for (int i = 0; i < tbl[c].n; i++) begin
                byte_in    = 8'(int'(tbl[c].start) + int'(tbl[c].step) * i);
                byte_valid = 1'b1;
                tick();
            end
            byte_valid  = 1'b0;
            stream_done = 1'b1;
            tick();
            stream_done = 1'b0;
            if (tbl[c].stall) begin
                repeat (5) tick();
                chk($sformatf("v%0d_stalled_req", c), 32'(wr_req), 32'd1);
                chk($sformatf("v%0d_stalled_cnt", c), 32'(got_data.size()), 32'd0);
                wr_ack = 1'b1;
            end
            wait_done(1'b0);
            chk($sformatf("v%0d_nwrites", c), 32'(got_data.size()), 32'(tbl[c].nw));
            if (got_data.size() == tbl[c].nw) begin
                chk($sformatf("v%0d_addr0", c), 32'(got_addr[0]), 32'(tbl[c].a0));
                chk($sformatf("v%0d_data0", c), got_data[0], tbl[c].d0);
                chk($sformatf("v%0d_addrl", c), 32'(got_addr[tbl[c].nw-1]), 32'(tbl[c].al));
                chk($sformatf("v%0d_datal", c), got_data[tbl[c].nw-1], tbl[c].dl);
            end
            chk($sformatf("v%0d_overflow", c), 32'(overflow), 32'(tbl[c].ovf));
            chk($sformatf("v%0d_done_cnt", c), 32'(done_cnt), 32'd1);
            chk($sformatf("v%0d_done_after_ack", c), 32'(done_cyc > last_ack_cyc), 32'd1);
            if (tbl[c].stall)
                chk($sformatf("v%0d_done_lat", c), 32'(done_cyc - last_ack_cyc), 32'd1);
            chk($sformatf("v%0d_idle_req", c), 32'(wr_req), 32'd0);
        end

        // Reset with three words queued
        wr_ack = 1'b0;
        start_frame(16'h4000);
        for (int i = 0; i < 12; i++) begin
            byte_in    = 8'(i + 8'h50);
            byte_valid = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        tick();
        chk("rstmid_req_before", 32'(wr_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(wr_req), 32'd0);
        chk("rstmid_addr", 32'(wr_addr), 32'd0);
        chk("rstmid_data", wr_data, 32'd0);
        tick();
        reset_n = 1'b1;
        got_addr.delete();
        got_data.delete();
        done_cnt = 0;
        wr_ack   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            byte_in     = 8'($urandom);
            byte_valid  = 1'b1;
            stream_done = (i == 8);
            tick();
        end
        byte_valid  = 1'b0;
        stream_done = 1'b0;
        repeat (4) tick();
        chk("rstmid_no_writes", 32'(got_data.size()), 32'd0);
        chk("rstmid_no_done", 32'(done_cnt), 32'd0);
        chk("rstmid_idle_req", 32'(wr_req), 32'd0);

        // Random frames against a word-list model
        for (int f = 0; f < 20; f++) begin
            logic [15:0] base;
            int          n;
            int          idx;
            int          sent;
            bit          sdone;
            base = 16'($urandom);
            if (f == 0) base = 16'hFFFE;
            n    = $urandom_range(1, 30);
            stim.delete();
            exp_w.delete();
            for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
            for (int k = 0; k < (n + 3) / 4; k++) begin
                logic [31:0] w;
                w = '0;
                for (int j = 0; j < 4; j++)
                    if (4 * k + j < n) w[8*j +: 8] = stim[4*k+j];
                exp_w.push_back(w);
            end

            wr_ack = 1'b1;
            start_frame(base);
            idx   = 0;
            sent  = 0;
            sdone = 1'b0;
            while (idx < n) begin
                byte_valid  = ($urandom % 2) != 0;
                byte_in     = stim[idx];
                stream_done = 1'b0;
                if (byte_valid) begin
                    idx++;
                    if (idx % 4 == 0) sent++;
                    if (idx == n && ($urandom % 2) != 0) begin
                        stream_done = 1'b1;
                        sdone       = 1'b1;
                    end
                end
                wr_ack = ((sent - got_data.size()) >= 2) ? 1'b1 : (($urandom % 4) != 0);
                tick();
            end
            byte_valid  = 1'b0;
            stream_done = 1'b0;
            if (!sdone) begin
                stream_done = 1'b1;
                tick();
                stream_done = 1'b0;
            end
            wait_done(1'b1);

            chk($sformatf("r%0d_nwrites", f), 32'(got_data.size()), 32'(exp_w.size()));
            for (int k = 0; k < exp_w.size() && k < got_data.size(); k++) begin
                chk($sformatf("r%0d_addr%0d", f, k), 32'(got_addr[k]), 32'(16'(base + 16'(k))));
                chk($sformatf("r%0d_data%0d", f, k), got_data[k], exp_w[k]);
            end
            chk($sformatf("r%0d_overflow", f), 32'(overflow), 32'd0);
            chk($sformatf("r%0d_done_cnt", f), 32'(done_cnt), 32'd1);
            chk($sformatf("r%0d_done_after_ack", f), 32'(done_cyc > last_ack_cyc), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
